// File: rtl/aim65_pkg.sv
// Shared definitions for the AIM65 memory map.
// Contents:
//   WAIT_W        - width of the wait-state counter (wait counts 0..7)
//   region_e      - decoded address region codes
//   *_LO / *_HI   - address-range boundaries of every mapped region
//   decode_region - address to region decoder
//   is_rom/is_io  - region classifiers used to pick the wait count
package aim65_pkg;

    localparam int WAIT_W = 3;

    typedef enum logic [3:0] {
        REG_RAM  = 4'd0,
        REG_Z22  = 4'd1,
        REG_Z23  = 4'd2,
        REG_Z24  = 4'd3,
        REG_Z25  = 4'd4,
        REG_Z26  = 4'd5,
        REG_IO0  = 4'd6,
        REG_IO1  = 4'd7,
        REG_IO2  = 4'd8,
        REG_IO3  = 4'd9,
        REG_NONE = 4'd10
    } region_e;

    localparam logic [15:0] RAM_HI = 16'h7FFF;
    localparam logic [15:0] IO0_LO = 16'hA000;
    localparam logic [15:0] IO0_HI = 16'hA00F;
    localparam logic [15:0] IO1_LO = 16'hA400;
    localparam logic [15:0] IO1_HI = 16'hA4FF;
    localparam logic [15:0] IO2_LO = 16'hA800;
    localparam logic [15:0] IO2_HI = 16'hA80F;
    localparam logic [15:0] IO3_LO = 16'hAC00;
    localparam logic [15:0] IO3_HI = 16'hAC03;
    localparam logic [15:0] Z25_LO = 16'hB000;
    localparam logic [15:0] Z26_LO = 16'hC000;
    localparam logic [15:0] Z24_LO = 16'hD000;
    localparam logic [15:0] Z23_LO = 16'hE000;
    localparam logic [15:0] Z22_LO = 16'hF000;
    // Start of the ROM window; writes at or above this address are protected.
    localparam logic [15:0] ROM_LO = 16'hB000;

    function automatic region_e decode_region(input logic [15:0] a);
        region_e r;
        if (a <= RAM_HI) begin
            r = REG_RAM;
        end else if (a >= IO0_LO && a <= IO0_HI) begin
            r = REG_IO0;
        end else if (a >= IO1_LO && a <= IO1_HI) begin
            r = REG_IO1;
        end else if (a >= IO2_LO && a <= IO2_HI) begin
            r = REG_IO2;
        end else if (a >= IO3_LO && a <= IO3_HI) begin
            r = REG_IO3;
        end else if (a >= Z22_LO) begin
            r = REG_Z22;
        end else if (a >= Z23_LO) begin
            r = REG_Z23;
        end else if (a >= Z24_LO) begin
            r = REG_Z24;
        end else if (a >= Z26_LO) begin
            r = REG_Z26;
        end else if (a >= Z25_LO) begin
            r = REG_Z25;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

    function automatic logic is_rom(input region_e r);
        logic v;
        case (r)
            REG_Z22, REG_Z23, REG_Z24, REG_Z25, REG_Z26: v = 1'b1;
            default:                                     v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic is_io(input region_e r);
        logic v;
        case (r)
            REG_IO0, REG_IO1, REG_IO2, REG_IO3: v = 1'b1;
            default:                            v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aim65_memmap_if.sv
// CPU-side bus between the 65C02 and the memory-map block.
// Signals:
//   addr     - CPU address
//   rw       - 1 = read, 0 = write
//   cpu_dout - CPU write data
//   cpu_data - read data returned to the CPU
//   rdy      - CPU ready (low inserts wait states)
// Modports: master (CPU side), slave (memory map side).
interface aim65_memmap_if #(
    parameter int DATA_W = 8
);
    logic [15:0]       addr;
    logic              rw;
    logic [DATA_W-1:0] cpu_dout;
    logic [DATA_W-1:0] cpu_data;
    logic              rdy;

    modport master (output addr, output rw, output cpu_dout, input cpu_data, input rdy);
    modport slave  (input addr, input rw, input cpu_dout, output cpu_data, output rdy);
endinterface

// File: rtl/aim65_waitgen.sv
// Wait-state generator: stretches an accepted access by N cycles via RDY.
// Ports:
//   cpu_clk    - clock
//   reset_n    - asynchronous active-low reset
//   i_wait_cnt - wait count for the address presented this cycle
//   i_accept   - the current cycle is accepted by the CPU
//   o_rdy      - registered CPU ready
module aim65_waitgen
    import aim65_pkg::*;
(
    input  logic              cpu_clk,
    input  logic              reset_n,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    input  logic              i_accept,
    output logic              o_rdy
);

    localparam logic [0:0] ST_ACCEPT = 1'b0;
    localparam logic [0:0] ST_WAIT   = 1'b1;

    logic [0:0]        r_state;
    logic [WAIT_W-1:0] r_cnt;
    logic              r_rdy;

    // Wait FSM: ready drops the cycle after acceptance and stays low for N cycles.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ACCEPT;
            r_cnt   <= {WAIT_W{1'b0}};
            r_rdy   <= 1'b1;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (i_accept && (i_wait_cnt != {WAIT_W{1'b0}})) begin
                        r_cnt   <= i_wait_cnt;
                        r_rdy   <= 1'b0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_rdy   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // The count reaching 1 marks the last low cycle.
                    if (r_cnt == WAIT_W'(1)) begin
                        r_cnt   <= {WAIT_W{1'b0}};
                        r_rdy   <= 1'b1;
                        r_state <= ST_ACCEPT;
                    end else begin
                        r_cnt   <= r_cnt - WAIT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= {WAIT_W{1'b0}};
                    r_rdy   <= 1'b1;
                    r_state <= ST_ACCEPT;
                end
            endcase
        end
    end

    assign o_rdy = r_rdy;

endmodule

// File: rtl/aim65_memmap.sv
// AIM65 address decoder, banked language-ROM selector and read mux.
// Ports:
//   cpu_clk, reset_n      - clock, asynchronous active-low reset
//   bus                   - CPU bus (addr, rw, cpu_dout in; cpu_data, rdy out)
//   ext_selector          - front-panel bank choice, asynchronous
//   ram_do, z22..z24_do   - device read data
//   z25_do, z26_do        - per-bank read data, bank b at [b*DATA_W +: DATA_W]
//   io_do                 - [0] A0 VIA, [1] A4 RIOT, [2] A8 VIA, [3] AC PIA
//   ram_cs, z22..z26_cs   - combinational chip selects
//   io_cs                 - combinational I/O selects
//   bank                  - current language-ROM bank
//   wp_err                - one-cycle pulse on a write into the ROM window
module aim65_memmap
    import aim65_pkg::*;
#(
    parameter int                DATA_W        = 8,
    parameter int                NUM_BANKS     = 4,
    parameter int                BANK_W        = $clog2(NUM_BANKS),
    parameter logic [15:0]       BANK_REG_ADDR = 16'hAFF0,
    parameter int                ROM_WAIT      = 1,
    parameter int                IO_WAIT       = 0,
    parameter logic [DATA_W-1:0] OPEN_BUS      = 8'hFF
) (
    input  logic                        cpu_clk,
    input  logic                        reset_n,
    aim65_memmap_if.slave               bus,
    input  logic [BANK_W-1:0]           ext_selector,
    input  logic [DATA_W-1:0]           ram_do,
    input  logic [DATA_W-1:0]           z22_do,
    input  logic [DATA_W-1:0]           z23_do,
    input  logic [DATA_W-1:0]           z24_do,
    input  logic [NUM_BANKS*DATA_W-1:0] z25_do,
    input  logic [NUM_BANKS*DATA_W-1:0] z26_do,
    input  logic [4*DATA_W-1:0]         io_do,
    output logic                        ram_cs,
    output logic                        z22_cs,
    output logic                        z23_cs,
    output logic                        z24_cs,
    output logic                        z25_cs,
    output logic                        z26_cs,
    output logic [3:0]                  io_cs,
    output logic [BANK_W-1:0]           bank,
    output logic                        wp_err
);

    function automatic logic [BANK_W-1:0] clamp_bank(input logic [BANK_W-1:0] v);
        logic [BANK_W-1:0] r;
        if ({1'b0, v} >= (BANK_W+1)'(NUM_BANKS)) begin
            r = BANK_W'(NUM_BANKS - 1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    region_e           w_region;
    logic [WAIT_W-1:0] w_wait_cnt;
    logic              w_rdy;
    logic              w_accept;
    logic              w_bank_wr;
    logic              w_wp;
    logic              w_sel_chg;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_dout;

    region_e           r_region;
    logic [BANK_W-1:0] r_rd_bank;
    logic [BANK_W-1:0] r_bank;
    logic [BANK_W-1:0] r_sel_meta;
    logic [BANK_W-1:0] r_sel_sync;
    logic [BANK_W-1:0] r_sel_prev;
    logic [1:0]        r_ign;
    logic              r_wp_err;

    assign w_region = decode_region(bus.addr);

    // Selects follow the address only; rw and rdy play no part.
    assign ram_cs = (w_region == REG_RAM);
    assign z22_cs = (w_region == REG_Z22);
    assign z23_cs = (w_region == REG_Z23);
    assign z24_cs = (w_region == REG_Z24);
    assign z25_cs = (w_region == REG_Z25);
    assign z26_cs = (w_region == REG_Z26);
    assign io_cs  = {(w_region == REG_IO3), (w_region == REG_IO2),
                     (w_region == REG_IO1), (w_region == REG_IO0)};

    // Wait count for the region currently on the bus.
    always_comb begin
        w_wait_cnt = WAIT_W'(0);
        if (is_rom(w_region)) begin
            w_wait_cnt = WAIT_W'(ROM_WAIT);
        end else if (is_io(w_region)) begin
            w_wait_cnt = WAIT_W'(IO_WAIT);
        end else begin
            w_wait_cnt = WAIT_W'(0);
        end
    end

    assign w_accept  = w_rdy;
    assign w_bank_wr = w_accept && !bus.rw && (bus.addr == BANK_REG_ADDR);
    assign w_wp      = w_accept && !bus.rw && (bus.addr >= ROM_LO) && (bus.addr != BANK_REG_ADDR);
    assign w_sel_chg = (r_sel_sync != r_sel_prev);

    // Only the low bank bits of the write data are consumed.
    assign w_unused_dout = ^bus.cpu_dout;

    aim65_waitgen u_waitgen (
        .cpu_clk    (cpu_clk),
        .reset_n    (reset_n),
        .i_wait_cnt (w_wait_cnt),
        .i_accept   (w_accept),
        .o_rdy      (w_rdy)
    );

    // Bank register fed by CPU writes and the synchronised front-panel selector.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_meta <= {BANK_W{1'b0}};
            r_sel_sync <= {BANK_W{1'b0}};
            r_sel_prev <= {BANK_W{1'b0}};
            r_bank     <= {BANK_W{1'b0}};
            r_ign      <= 2'd0;
        end else begin
            r_sel_meta <= ext_selector;
            r_sel_sync <= r_sel_meta;
            r_sel_prev <= r_sel_sync;
            // A CPU write wins; selector changes still travelling through the
            // two-flop synchroniser when it happens are swallowed via r_ign.
            if (w_bank_wr) begin
                r_bank <= clamp_bank(bus.cpu_dout[BANK_W-1:0]);
                r_ign  <= 2'd2;
            end else begin
                if (w_sel_chg && (r_ign == 2'd0)) begin
                    r_bank <= clamp_bank(r_sel_sync);
                end else begin
                    r_bank <= r_bank;
                end
                if (r_ign != 2'd0) begin
                    r_ign <= r_ign - 2'd1;
                end else begin
                    r_ign <= r_ign;
                end
            end
        end
    end

    // Region and bank are captured on accepted cycles so an in-flight access
    // keeps the bank it started with.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_region  <= REG_NONE;
            r_rd_bank <= {BANK_W{1'b0}};
            r_wp_err  <= 1'b0;
        end else begin
            r_wp_err <= w_wp;
            if (w_accept) begin
                r_region  <= w_region;
                r_rd_bank <= r_bank;
            end else begin
                r_region  <= r_region;
                r_rd_bank <= r_rd_bank;
            end
        end
    end

    // Read mux steered by the registered region, aligned with 1-cycle devices.
    always_comb begin
        w_rd_data = OPEN_BUS;
        case (r_region)
            REG_RAM:  w_rd_data = ram_do;
            REG_Z22:  w_rd_data = z22_do;
            REG_Z23:  w_rd_data = z23_do;
            REG_Z24:  w_rd_data = z24_do;
            REG_Z25:  w_rd_data = z25_do[int'(r_rd_bank)*DATA_W +: DATA_W];
            REG_Z26:  w_rd_data = z26_do[int'(r_rd_bank)*DATA_W +: DATA_W];
            REG_IO0:  w_rd_data = io_do[0*DATA_W +: DATA_W];
            REG_IO1:  w_rd_data = io_do[1*DATA_W +: DATA_W];
            REG_IO2:  w_rd_data = io_do[2*DATA_W +: DATA_W];
            REG_IO3:  w_rd_data = io_do[3*DATA_W +: DATA_W];
            default:  w_rd_data = OPEN_BUS;
        endcase
    end

    assign bus.cpu_data = w_rd_data;
    assign bus.rdy      = w_rdy;
    assign bank         = r_bank;
    assign wp_err       = r_wp_err;

endmodule

// File: doc/aim65_memmap.md
# aim65_memmap

Parametrised, registered successor to the AIM65 address decoder/read mux. Decodes the 65C02 address bus into chip selects for RAM, the monitor and assembler ROMs, the banked Z25/Z26 language-ROM pair and the four I/O chips. Adds features the current decoder lacks:
- a CPU-writable bank register for NUM_BANKS language-ROM sets;
- per-region wait-state insertion through RDY;
- a write-protect error strobe.

It sits between `cpu_65c02` and the memory/peripheral instances in `aim65`.

## Interface
Parameters:
- DATA_W, 8, data bus width
- NUM_BANKS, 4, language-ROM sets behind Z25/Z26 (≥2)
- BANK_W, $clog2(NUM_BANKS), bank select width
- BANK_REG_ADDR, 16'hAFF0, write-only bank register address
- ROM_WAIT, 1, RDY-low cycles per ROM access (0–7)
- IO_WAIT, 0, RDY-low cycles per I/O access (0–7)
- OPEN_BUS, 8'hFF, read value for unmapped addresses

Ports:
- cpu_clk, in, 1, sole clock
- reset_n, in, 1, asynchronous active-low reset
- addr, in, 16, CPU address
- rw, in, 1, 1 = read, 0 = write
- cpu_dout, in, DATA_W, CPU write data
- ext_selector, in, BANK_W, front-panel bank choice (quasi-static)
- ram_do, z22_do, z23_do, z24_do, in, DATA_W each, device read data
- z25_do, z26_do, in, NUM_BANKS*DATA_W each, bank b at bits [b*DATA_W +: DATA_W]
- io_do, in, 4*DATA_W, [0] = A0 VIA, [1] = A4 RIOT, [2] = A8 VIA, [3] = AC PIA
- ram_cs, z22_cs … z26_cs, out, 1 each, combinational selects
- io_cs, out, 4, combinational I/O selects
- bank, out, BANK_W, current language-ROM bank
- cpu_data, out, DATA_W, registered read data to CPU
- rdy, out, 1, CPU ready
- wp_err, out, 1, one-cycle write-to-ROM pulse

## Operation
- Address map:
  - 0000–7FFF RAM
  - A000–A00F io0; A400–A4FF io1; A800–A80F io2; AC00–AC03 io3
  - B000–BFFF Z25; C000–CFFF Z26; D000–DFFF Z24; E000–EFFF Z23; F000–FFFF Z22
  - everything else is unmapped
- Chip selects: combinational from addr, asserted regardless of rdy. ROM selects ignore rw.
- Bank register:
  - resets to 0;
  - loads cpu_dout[BANK_W-1:0] on a cycle with rw = 0, addr = BANK_REG_ADDR, rdy = 1;
  - loads ext_selector on any change of its 2-flop-synchronised value.
  - Simultaneous CPU write and selector change: CPU write wins; the selector change is dropped.
  - Values ≥ NUM_BANKS are clamped to NUM_BANKS-1.
- Read mux:
  - region code and bank are registered at each accepted cycle (rdy = 1);
  - cpu_data is driven from the registered region, which matches the synchronous 1-cycle device latency;
  - unmapped → OPEN_BUS.
- wp_err pulses for one cycle when an accepted cycle has rw = 0 and addr is in B000–FFFF, excluding BANK_REG_ADDR. The write is not forwarded (no cs change beyond the select).
- Wait FSM:
  - states ACCEPT, WAIT.
  - In ACCEPT with a ROM/IO region and its wait count N > 0: load counter = N, rdy drops next cycle, go to WAIT.
  - In WAIT: decrement; at counter = 1, rdy = 1 and return to ACCEPT.
  - N = 0 regions never leave ACCEPT.
  - RAM and unmapped regions always use N = 0.

## Timing
- Reset values: bank = 0, rdy = 1, cpu_data = OPEN_BUS, wp_err = 0, FSM = ACCEPT, region register = unmapped.
- Read data for an accepted address is valid on cpu_data in the cycle after acceptance, plus N cycles when waits apply.
- rdy low time equals exactly N consecutive cycles per access. Back-to-back ROM accesses each pay N.
- Bank changes affect the first access accepted after the register updates. An in-flight access keeps its registered bank.
- Asserting reset_n mid-WAIT aborts immediately: rdy = 1 and all state returns to reset values.

## Structure
- Package aim65_pkg holds:
  - region enum (REG_RAM, REG_Z22 … REG_Z26, REG_IO0–3, REG_NONE);
  - address-range constants;
  - the wait-count width constant.
- One sub-module, aim65_waitgen, contains the wait FSM and counter. Inputs: wait count and accept strobe; output: rdy.
- Decode, bank register and read mux stay in aim65_memmap.

## Test plan
- Read 0x1234 (RAM) with ram_do = 8'h5A → cpu_data = 8'h5A one cycle later; rdy never low.
- ROM_WAIT = 2, read F000 → z22_cs = 1; rdy low for exactly 2 cycles; cpu_data = z22_do afterwards.
- Write 8'h02 to AFF0, then read B010 → bank = 2; cpu_data = z25_do[23:16].
- In the same cycle, write bank 1 and change ext_selector to 3 → bank = 1. Then change ext_selector to 0 → bank = 0 within 3 cycles.
- Write to D000 → wp_err = 1 for one cycle. Read 9000 → cpu_data = 8'hFF; no cs asserted.
- Deassert-then-reassert reset_n during WAIT → rdy = 1 and bank = 0 immediately; the next access behaves as from reset.
